// File: rtl/input_layer_pkg.sv
// input_layer_pkg: shared state encoding and geometry for the input-layer pipeline.
package input_layer_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int LANES_INT8 = 4;
  localparam int LANES_FP16 = 2;
  localparam int IN_WORD_W  = 32;
  localparam int SAMPLE_W   = 16;
endpackage

// File: rtl/unpack_lane_mux.sv
// unpack_lane_mux: selects one lane of a packed word as a 16-bit sample.
// INPUT_UNPACK_LANE_SWAP_EN reverses lane order (MSB-first).
module unpack_lane_mux import input_layer_pkg::*; (
  input  logic [IN_WORD_W-1:0] word,
  input  logic [1:0]           lane,
  input  logic                 mode,
  output logic [SAMPLE_W-1:0]  sample
);
  logic [1:0] k;
  logic [7:0] b;
  logic [15:0] h;
`ifdef INPUT_UNPACK_LANE_SWAP_EN
  assign k = ~lane;
`else
  assign k = lane;
`endif
  assign b = 8'(word >> {k, 3'b000});
  assign h = 16'(word >> {k[0], 4'b0000});
  assign sample = mode ? {{8{b[7]}}, b} : h;
endmodule

// File: rtl/input_word_unpacker.sv
// input_word_unpacker: serialises 32-bit input words into 16-bit samples per frame.
// Optional INPUT_UNPACK_LANE_SWAP_EN (in unpack_lane_mux) emits lanes MSB-first.
module input_word_unpacker import input_layer_pkg::*; #(
  parameter int FRAME_LEN_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   cfg_cast,
  input  logic [FRAME_LEN_W-1:0] cfg_frame_len,
  input  logic [31:0]            s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [15:0]            m_data,
  output logic                   m_cast,
  output logic                   m_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   busy,
  output logic                   done
);
  state_t state_q;
  logic mode_q, wv_q, done_q;
  logic [FRAME_LEN_W-1:0] len_q, count_q;
  logic [31:0] word_q;
  logic [1:0] lane_q, last_lane;
  logic fire, at_last, accept;
  assign last_lane = mode_q ? 2'(LANES_INT8 - 1) : 2'(LANES_FP16 - 1);
  assign at_last = lane_q == last_lane;
  assign fire = wv_q && m_ready;
  assign m_valid = wv_q;
  assign m_cast = mode_q;
  assign m_last = wv_q && (count_q == len_q - FRAME_LEN_W'(1));
  // Refill only when the current word drains and the frame continues.
  assign s_ready = (state_q == RUN) && (!wv_q || (fire && at_last && !m_last));
  assign accept = s_valid && s_ready;
  assign busy = state_q == RUN;
  assign done = done_q;
  unpack_lane_mux u_mux (
    .word   (word_q),
    .lane   (lane_q),
    .mode   (mode_q),
    .sample (m_data)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      len_q   <= '0;
      count_q <= '0;
      word_q  <= '0;
      wv_q    <= 1'b0;
      lane_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          mode_q  <= cfg_cast;
          len_q   <= cfg_frame_len;
          count_q <= '0;
          lane_q  <= '0;
          wv_q    <= 1'b0;
          state_q <= (cfg_frame_len == '0) ? IDLE : RUN;
          done_q  <= cfg_frame_len == '0;
        end
      end else begin
        if (fire) begin
          count_q <= count_q + FRAME_LEN_W'(1);
          if (m_last) begin
            wv_q    <= 1'b0;
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else if (at_last)
            wv_q <= 1'b0;
          else
            lane_q <= lane_q + 2'd1;
        end
        if (accept) begin
          word_q <= s_data;
          wv_q   <= 1'b1;
          lane_q <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_input_word_unpacker.sv
// tb_input_word_unpacker: scoreboard bench for input_word_unpacker.
module tb_input_word_unpacker;
  logic clk = 0, reset_n = 0, start = 0, cfg_cast = 0;
  logic [15:0] cfg_frame_len = 0;
  logic [31:0] s_data = 0;
  logic s_valid = 0, s_ready, m_cast, m_last, m_valid, busy, done;
  logic m_ready = 0;
  logic [15:0] m_data;
  int errors = 0, checks = 0, cyc = 0;
  int n_fire, first_fire, last_fire, acc_cnt, done_cnt, done_cyc;
  bit held, bp;
  logic [15:0] held_data;
  logic [17:0] exp_q[$];

  input_word_unpacker dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_cast(cfg_cast),
    .cfg_frame_len(cfg_frame_len), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .m_data(m_data), .m_cast(m_cast), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (bp) m_ready = ~m_ready;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] exp_sample(logic [31:0] w, int k, bit cast, bit last);
    int j;
    logic [7:0] b;
    logic [15:0] h;
`ifdef INPUT_UNPACK_LANE_SWAP_EN
    j = cast ? 3 - k : 1 - k;
`else
    j = k;
`endif
    b = w[8*j +: 8];
    h = w[16*j +: 16];
    return {last, cast, cast ? {{8{b[7]}}, b} : h};
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (held) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, held_data);
      end
      held = m_valid && !m_ready;
      held_data = m_data;
      if (held) check("sready_hold", s_ready, 0);
      if (s_valid && s_ready) acc_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected", 0, 1);
        else check("sample", {m_last, m_cast, m_data}, exp_q.pop_front());
        if (n_fire == 0) first_fire = cyc;
        last_fire = cyc;
        n_fire++;
      end
    end else held = 0;
  end

  task automatic send(logic [31:0] w);
    bit acc = 0;
    s_valid = 1;
    s_data = w;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 0, 1);
    s_valid = 0;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_m_cast"}, m_cast, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic run_frame(bit cast, int len, logic [31:0] w0, logic [31:0] w1,
                           logic [31:0] w2, bit extra, bit poke, bit no_bubble);
    logic [31:0] words[3];
    int lanes, nw;
    words = '{w0, w1, w2};
    lanes = cast ? 4 : 2;
    nw = (len + lanes - 1) / lanes;
    for (int i = 0; i < len; i++)
      exp_q.push_back(exp_sample(words[i/lanes], i % lanes, cast, i == len - 1));
    n_fire = 0; acc_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1; cfg_cast = cast; cfg_frame_len = 16'(len);
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < nw; i++) begin
      if (poke && i == 1) begin
        start = 1; cfg_cast = !cast; cfg_frame_len = 0;
        @(posedge clk); #1;
        start = 0;
      end
      send(words[i]);
    end
    s_valid = extra;
    s_data = 32'hDEAD_BEEF;
    for (int t = 0; t < 200 && done_cnt == 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    s_valid = 0;
    check("done_once", done_cnt, 1);
    check("done_lat", done_cyc, last_fire + 1);
    check("words_acc", acc_cnt, nw);
    check("n_samples", n_fire, len);
    check("sb_empty", exp_q.size(), 0);
    check("idle_busy", busy, 0);
    if (no_bubble) check("no_bubble", last_fire - first_fire, len - 1);
  endtask

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    @(posedge clk); #1;
    reset_n = 1;
    m_ready = 1;
    run_frame(1, 4, 32'h7F80_01FF, 0, 0, 0, 0, 1);
    run_frame(0, 5, 32'h3C00_4000, 32'hC000_3800, 32'h1111_2222, 1, 0, 1);
    bp = 1;
    run_frame(1, 8, 32'h8001_7FFE, 32'h1234_ABCD, 0, 0, 1, 0);
    bp = 0;
    @(posedge clk); #2;
    m_ready = 1;
    // zero-length frame: only a done pulse
    done_cnt = 0; acc_cnt = 0; n_fire = 0;
    s_valid = 1; s_data = 32'h5555_AAAA;
    start = 1; cfg_cast = 1; cfg_frame_len = 0;
    @(posedge clk); #1;
    start = 0;
    t0 = cyc;
    repeat (4) @(posedge clk);
    #1;
    s_valid = 0;
    check("len0_done", done_cnt, 1);
    check("len0_done_cyc", done_cyc, t0);
    check("len0_acc", acc_cnt, 0);
    check("len0_fire", n_fire, 0);
    check("len0_busy", busy, 0);
    // reset in the middle of a frame
    n_fire = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_sample(32'hA1B2_C3D4, i, 1, 0));
    start = 1; cfg_cast = 1; cfg_frame_len = 8;
    @(posedge clk); #1;
    start = 0;
    send(32'hA1B2_C3D4);
    s_valid = 1; s_data = 32'h0F0F_0F0F;
    for (int t = 0; t < 50 && n_fire < 2; t++) @(posedge clk);
    check("mid_fires", n_fire, 2);
    #1;
    reset_n = 0;
    s_valid = 0;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    check_zero("midrst");
    done_cnt = 0;
    @(posedge clk); #1;
    reset_n = 1;
    repeat (3) @(posedge clk);
    check("midrst_no_done", done_cnt, 0);
    #1;
    run_frame(1, 4, 32'h7F80_01FF, 0, 0, 0, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/input_word_unpacker.md
Name: input_word_unpacker

Overview:
Upstream feeder of the input-layer int-to-fp16 converter. Accepts 32-bit words from the input DMA stream and serialises them into one 16-bit sample per cycle with a per-sample cast flag. In cast mode each word carries four signed int8 pixels, each sign-extended to int16. In passthrough mode each word carries two fp16 values. Counts samples per frame, flags the last one, and discards unused lanes of the final word.

Parameters:
FRAME_LEN_W, 16, width of the frame-length counter in samples.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse: latch cfg_* and begin a frame
cfg_cast  in  1  1 = int8 cast mode, 0 = fp16 passthrough
cfg_frame_len  in  FRAME_LEN_W  samples in the frame
s_data  in  32  packed input word
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid && s_ready
m_data  out  16  output sample (int16 sign-extended, or raw fp16)
m_cast  out  1  cast flag for the sample; drives the converter cast_
m_last  out  1  final sample of the frame
m_valid  out  1  output sample valid
m_ready  in  1  downstream accepts when m_valid && m_ready
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the last sample is accepted

Behaviour:
- Reset: reset_n is synchronous, active-low; clock is clk. All outputs are 0; state is IDLE; word register is empty; lane and sample counters are 0. Reset mid-frame aborts the frame with no done pulse.
- States:
  - IDLE: s_ready=0, busy=0. start moves to RUN, latching cfg_cast into mode_q and cfg_frame_len into len_q, and clearing the sample count. If cfg_frame_len==0, go to IDLE next cycle with done=1 and produce no output.
  - RUN: busy=1.
- Start is ignored while busy.
- Word register (word_q, wv_q, lane_q):
  - s_ready = RUN && (!wv_q || (m_valid && m_ready && lane_q==LAST_LANE && !m_last)).
  - An accepted word loads word_q, sets wv_q=1 and clears lane_q.
  - Sustained throughput is one sample per cycle; back-to-back words are accepted without a bubble.
- Latency: a word accepted at edge N presents lane 0 on m_* after edge N (first-cycle visible).
- Output:
  - m_valid = wv_q.
  - m_data, m_cast and m_last are a combinational mux of the registered state and stay stable while m_valid && !m_ready.
  - Cast mode: LAST_LANE=3. Lane k = sign-extend word_q[8k+7:8k] to 16 bits (e.g. 0x80 -> 0xFF80).
  - Passthrough mode: LAST_LANE=1. Lane k = word_q[16k+15:16k].
- Handshake advance (m_valid && m_ready):
  - Sample count increments.
  - If lane_q==LAST_LANE, wv_q clears unless a new word is accepted the same cycle.
  - Otherwise lane_q increments.
- Frame end: m_last = (count == len_q-1). When that sample is accepted:
  - wv_q clears and remaining lanes are dropped.
  - Go to IDLE; done=1 the next cycle.
  - s_ready is 0 that cycle, so no word of the next frame is consumed.
- Count wrap is impossible: count is bounded by len_q (max 2^FRAME_LEN_W-1).
- s_valid deasserting mid-frame leaves m_valid=0 between words; the frame simply stalls.
- m_cast = mode_q for every sample of the frame.

Optional Feature:
- INPUT_UNPACK_LANE_SWAP_EN defined: lanes are emitted MSB-first. Cast mode emits lane k from word_q[31-8k:24-8k]; passthrough mode emits word_q[31:16] first.
- Undefined: LSB-first order as above.
- Counting, last and drop rules are identical in both cases.

Decomposition:
- Shared package input_layer_pkg:
  - state enum {IDLE, RUN}.
  - constants LANES_INT8=4, LANES_FP16=2, IN_WORD_W=32, SAMPLE_W=16.
  - These are reused by the converter and the downstream buffer.
- One natural sub-module: unpack_lane_mux, purely combinational. Inputs: word, lane, mode. Output: a 16-bit sample including sign extension and the optional swap. The top level keeps the FSM, counters and handshake.

Test Plan:
- Cast mode, len=4, word 0x7F80_01FF, m_ready=1 -> m_data FFFF, 0001, FF80, 007F on 4 consecutive cycles; m_cast=1; m_last on the 4th sample; done pulses 1 cycle later.
- Passthrough mode, len=5, words 0x3C00_4000, 0xC000_3800, 0x1111_2222 streamed back-to-back -> samples 4000, 3C00, 3800, C000, 2222 with no bubbles; lane 1111 dropped; m_cast=0; s_ready=0 after the third word.
- Backpressure: m_ready toggling 1010 during cast frame len=8 -> each sample held stable until accepted; no sample lost or duplicated; s_ready asserted only on the accepted last lane.
- len=0 start -> no m_valid and no s_ready; done=1 exactly one cycle later; start pulsed while busy in another run -> ignored, and the current frame completes normally.
- reset_n low mid-frame after 2 samples -> all outputs 0 the next cycle, no done; new start then runs a clean frame from lane 0.
- With INPUT_UNPACK_LANE_SWAP_EN, cast mode, len=4, word 0x7F80_01FF -> 007F, FF80, 0001, FFFF.
